// File: rtl/psum_out_fifo.sv
// First-word-fall-through FIFO buffering psum vectors from the PE core to the
// output consumer; throttles the core through its clock-gate enable before full.

module psum_out_fifo_lane #(
    parameter int depth = 8,
    parameter int bw    = 20,
    parameter int aw    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [aw-1:0] waddr,
    input  logic [bw-1:0] wdata,
    input  logic [aw-1:0] raddr,
    output logic [bw-1:0] rdata
);
    // Storage is deliberately not reset; pointers alone define validity.
    logic [bw-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

module psum_out_fifo #(
    parameter int col       = 8,
    parameter int bw_psum   = 20,
    parameter int depth     = 8,
    parameter int af_margin = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [col*bw_psum-1:0]   in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [col*bw_psum-1:0]   out_data,
    input  logic                     out_ready,
    output logic                     core_cg_en,
    output logic [$clog2(depth):0]   count,
    output logic                     overflow
);
    localparam int aw = $clog2(depth);
    localparam logic [aw:0]   cnt_full  = (aw+1)'(depth);
    localparam logic [aw:0]   cnt_one   = (aw+1)'(1);
    localparam logic [aw-1:0] ptr_one   = aw'(1);
    // Leave af_margin free slots for vectors already in flight when the gate closes.
    localparam logic [aw:0]   cg_thresh = (aw+1)'(depth - af_margin - 1);

    logic [aw-1:0] wr_ptr, rd_ptr;
    logic [aw:0]   count_next;
    logic          push, pop;

    logic [col-1:0][bw_psum-1:0] in_cols, out_cols;

    assign in_cols   = in_data;
    assign out_data  = out_cols;
    assign in_ready  = (count != cnt_full);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    for (genvar c = 0; c < col; c++) begin : g_col
        psum_out_fifo_lane #(.depth(depth), .bw(bw_psum), .aw(aw)) u_lane (
            .clk   (clk),
            .we    (push),
            .waddr (wr_ptr),
            .wdata (in_cols[c]),
            .raddr (rd_ptr),
            .rdata (out_cols[c])
        );
    end

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + cnt_one;
        else if (pop && !push) count_next = count - cnt_one;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            core_cg_en <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + ptr_one;
            if (pop)  rd_ptr <= rd_ptr + ptr_one;
            count      <= count_next;
            core_cg_en <= (count_next <= cg_thresh);
            if (in_valid && !in_ready) overflow <= 1'b1;
        end
    end
endmodule

// File: doc/psum_out_fifo.md
PSUM_OUT_FIFO -- requirements
Module: psum_out_fifo

Interface
REQ-001: The block SHALL have parameter col, default 8, meaning the number of psum columns per output vector.
REQ-002: The block SHALL have parameter bw_psum, default 20, meaning the bit width of one signed psum column.
REQ-003: The block SHALL have parameter depth, default 8 (power of 2, >=4), meaning the number of FIFO entries.
REQ-004: The block SHALL have parameter af_margin, default 2, meaning the free entries reserved to absorb the upstream clock-gate latency.
REQ-005: The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006: The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007: The block SHALL have port in_valid, input, 1 bit: the upstream core presents a psum vector.
REQ-008: The block SHALL have port in_data, input, col*bw_psum bits: the psum vector, with column 0 in the LSBs.
REQ-009: The block SHALL have port in_ready, output, 1 bit: an entry is free (not full).
REQ-010: The block SHALL have port out_valid, output, 1 bit: out_data holds the oldest entry.
REQ-011: The block SHALL have port out_data, output, col*bw_psum bits: the oldest stored vector.
REQ-012: The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts out_data.
REQ-013: The block SHALL have port core_cg_en, output, 1 bit: drives the E pin of the upstream core's CKLNQD2 clock gate.
REQ-014: The block SHALL have port count, output, log2(depth)+1 bits: the current occupancy.
REQ-015: The block SHALL have port overflow, output, 1 bit: a sticky flag set when data is dropped.

Function
REQ-016: A push SHALL occur on a clock edge where in_valid && in_ready, writing in_data at the write pointer.
REQ-017: A pop SHALL occur on a clock edge where out_valid && out_ready, advancing the read pointer.
REQ-018: The FIFO SHALL be first-word-fall-through: out_data equals the oldest entry combinationally from storage, and out_valid = (count != 0).
REQ-019: in_ready SHALL equal (count != depth); in_ready SHALL NOT depend combinationally on out_ready.
REQ-020: Latency SHALL be one cycle: data pushed at edge N is visible on out_data/out_valid after edge N when the FIFO was empty.
REQ-021: Read and write pointers SHALL be log2(depth) bits and wrap from depth-1 to 0 with no gap or skipped entry.
REQ-022: A simultaneous push and pop SHALL leave count unchanged; when count=0, only the push takes effect (no pop is possible).
REQ-023: When full, a simultaneous pop and in_valid SHALL NOT push, because in_ready=0; the input is dropped and overflow sets.
REQ-024: overflow SHALL set on any edge with in_valid=1 and in_ready=0, and SHALL remain set until reset.
REQ-025: count SHALL be updated as count + push - pop and SHALL never exceed depth or underflow below 0.
REQ-026: core_cg_en SHALL be registered, with next value (count_next <= depth - af_margin - 1), where count_next is the post-edge occupancy.
REQ-027: core_cg_en SHALL go low no later than the edge on which occupancy reaches depth-af_margin, and SHALL return high on the edge where occupancy drops back to depth-af_margin-1.
REQ-028: Storage contents SHALL NOT be cleared by reset; only pointers, count, flags and core_cg_en are reset.
REQ-029: out_data SHALL be don't-care when out_valid=0, and the verification bench SHALL NOT check it then.

Reset
REQ-030: On a reset=1 edge, wr_ptr, rd_ptr and count SHALL become 0, overflow SHALL become 0, and core_cg_en SHALL become 1.
REQ-031: In the cycle after reset, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-032: Reset SHALL take priority over a simultaneous push or pop; a reset mid-stream SHALL discard all stored entries.

Verification
REQ-033: Scenario: reset, then push vectors 1..8 (col0=k, others 0) with out_ready=0 -> count=8, in_ready=0, out_valid=1, out_data col0=1, overflow=0.
REQ-034: Scenario: from full, assert in_valid with data 9 for one cycle -> overflow=1 and sticky, count stays 8; then drain -> 1..8 in order, 9 never appears.
REQ-035: Scenario: with depth=8 and af_margin=2, push one vector per cycle -> core_cg_en falls after the edge making count=6; pop one -> core_cg_en rises after count=5.
REQ-036: Scenario: with count=3, push and pop on the same edge for 20 cycles using an incrementing pattern -> count stays 3, output order is preserved, and the pointers wrap at least twice.
REQ-037: Scenario: with count=5, assert reset together with in_valid and out_ready -> next cycle count=0, out_valid=0, core_cg_en=1, overflow=0.
REQ-038: Scenario: push signed extremes per column (col k = -2^19 for even k, 2^19-1 for odd k) -> out_data bit-exact, with no sign or column swap.
